rr_arbiter8: RTL

Eight-requester round-robin arbiter. It selects one requester at a time, holds the grant until release, requester drop, or hold timeout, and drives the winning channel as a 3-bit index. It sits directly upstream of the 3-to-8 decoder. `grant_idx` feeds the decoder select input, and the decoder's one-hot output, gated by `grant_valid`, forms the per-channel grant lines.

---
 rtl/rr_arbiter8_if.sv | 36 +++
 rtl/rr_arbiter8.sv | 122 ++++++++++++
 2 files changed

// File: rtl/rr_arbiter8_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rr_arbiter8_if
// Description : Request/grant bundle between the requesters and the
//               eight-channel round-robin arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface rr_arbiter8_if;
   logic [7:0] req;            // bit i high = channel i requests
   logic       release_grant;  // current owner finished (sampled while granted)
   logic       grant_valid;    // a grant is active
   logic [2:0] grant_idx;      // granted channel, decoder select
   logic       timeout;        // one-cycle pulse on forced revocation
   logic [7:0] grant_count;    // grants issued, saturating at 255

   // Arbiter side: consumes requests, produces grants.
   modport master (
      input  req,
      input  release_grant,
      output grant_valid,
      output grant_idx,
      output timeout,
      output grant_count
   );

   // Requester side: produces requests, consumes grants.
   modport slave (
      output req,
      output release_grant,
      input  grant_valid,
      input  grant_idx,
      input  timeout,
      input  grant_count
   );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rr_arbiter8
// Description : Eight-requester round-robin arbiter. Holds a grant until the
//               owner releases, drops its request, or HOLD_MAX cycles elapse.
//               All outputs are registered.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module rr_arbiter8 #(
   parameter int HOLD_MAX = 15   // legal range 1..255
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   rr_arbiter8_if.master bus
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Last hold_cnt value before a forced end; the grant then spans HOLD_MAX cycles.
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   state_t     state, state_nxt;
   logic [2:0] ptr, ptr_nxt;
   logic [7:0] hold_cnt, hold_nxt;
   logic       grant_valid, valid_nxt;
   logic [2:0] grant_idx, idx_nxt;
   logic       timeout, timeout_nxt;
   logic [7:0] grant_count, count_nxt;

   logic [2:0] winner;
   logic       any_req;

   // Round-robin search: first requesting channel at or after ptr, wrapping mod 8.
   always_comb begin
      logic [2:0] cand;
      winner  = ptr;
      any_req = 1'b0;
      // Scan from the farthest offset down so the nearest hit is kept last.
      for (int k = 7; k >= 0; k--) begin
         cand = ptr + 3'(k);
         if (bus.req[cand]) begin
            winner  = cand;
            any_req = 1'b1;
         end
      end
   end

   // Next-state and next-output logic for the IDLE/GRANT machine.
   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      hold_nxt    = hold_cnt;
      valid_nxt   = grant_valid;
      idx_nxt     = grant_idx;
      timeout_nxt = 1'b0;
      count_nxt   = grant_count;

      unique case (state)
         IDLE: begin
            if (any_req) begin
               idx_nxt   = winner;
               valid_nxt = 1'b1;
               hold_nxt  = 8'd0;
               count_nxt = (grant_count != 8'hFF) ? grant_count + 8'd1 : grant_count;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (bus.release_grant || !bus.req[grant_idx]) begin
               // Normal end; takes priority over a coincident hold limit.
               valid_nxt = 1'b0;
               ptr_nxt   = grant_idx + 3'd1;
               hold_nxt  = 8'd0;
               state_nxt = IDLE;
            end else if (hold_cnt == HOLD_LAST) begin
               valid_nxt   = 1'b0;
               ptr_nxt     = grant_idx + 3'd1;
               hold_nxt    = 8'd0;
               timeout_nxt = 1'b1;
               state_nxt   = IDLE;
            end else begin
               hold_nxt = hold_cnt + 8'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= 3'd0;
         hold_cnt    <= 8'd0;
         grant_valid <= 1'b0;
         grant_idx   <= 3'd0;
         timeout     <= 1'b0;
         grant_count <= 8'd0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         hold_cnt    <= hold_nxt;
         grant_valid <= valid_nxt;
         grant_idx   <= idx_nxt;
         timeout     <= timeout_nxt;
         grant_count <= count_nxt;
      end
   end

   assign bus.grant_valid = grant_valid;
   assign bus.grant_idx   = grant_idx;
   assign bus.timeout     = timeout;
   assign bus.grant_count = grant_count;

endmodule
`default_nettype wire
